// File: rtl/nibble_rot_pkg.sv
// Shared types and constants for the nibble rotator: FSM states, pattern table,
// direction encoding and the word loaded by reset.
package nibble_rot_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LOAD = 2'd2
  } state_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  localparam logic [WORD_W-1:0] PAT_00     = 16'h0123;
  localparam logic [WORD_W-1:0] PAT_01     = 16'hABCD;
  localparam logic [WORD_W-1:0] PAT_10     = 16'h000F;
  localparam logic [WORD_W-1:0] PAT_11     = 16'hF0F0;
  localparam logic [WORD_W-1:0] RESET_WORD = 16'h0123;

  // Pattern table lookup by debounced select
  function automatic logic [WORD_W-1:0] pattern_word(input logic [1:0] sel);
    case (sel)
      2'b00:   return PAT_00;
      2'b01:   return PAT_01;
      2'b10:   return PAT_10;
      default: return PAT_11;
    endcase
  endfunction

  // Whole-nibble rotation with wrap-around at both ends
  function automatic logic [WORD_W-1:0] rotate_nibble(input logic [WORD_W-1:0] w,
                                                      input dir_e dir);
    if (dir == DIR_RIGHT) return {w[3:0], w[15:4]};
    return {w[11:0], w[15:12]};
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// One switch bit: two-flop synchronizer followed by a counter debouncer that
// accepts a new level only after DEB_CYCLES consecutive differing samples.
module sw_debounce #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int unsigned CW = $clog2(DEB_CYCLES);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      dout   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], din};
      // Any sample matching the accepted level restarts the count
      if (sync_q[1] == dout) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        dout  <= sync_q[1];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/nibble_rotator.sv
// Rotates a 16-bit hex word one nibble per tick; switches select the pattern,
// direction and run/hold. t feeds the seven-segment driver directly.
module nibble_rotator
  import nibble_rot_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 25_000_000,
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic              CLK100MHZ,
  input  logic              CPU_RESET,
  input  logic [3:0]        sw_raw,
  output logic [WORD_W-1:0] t,
  output logic              t_valid
);

  localparam int unsigned TW = $clog2(TICK_DIV);

  logic [3:0]    sw_deb;
  logic [1:0]    pat_q;
  logic [TW-1:0] tick_cnt;
  state_e        state, next_state;
  logic          pat_chg, tick, rot_en, run;
  dir_e          dir;

  for (genvar i = 0; i < 4; i++) begin : g_deb
    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk  (CLK100MHZ),
      .rst  (CPU_RESET),
      .din  (sw_raw[i]),
      .dout (sw_deb[i])
    );
  end

  assign run = sw_deb[3];
  assign dir = dir_e'(sw_deb[2]);

  // Next state; a pattern change overrides everything, including a tick
  always_comb begin
    next_state = state;
    rot_en     = 1'b0;
    pat_chg    = (sw_deb[1:0] != pat_q);
    tick       = (tick_cnt == TW'(TICK_DIV - 1));
    if (pat_chg) begin
      next_state = LOAD;
    end else begin
      case (state)
        IDLE: if (run) next_state = RUN;
        RUN: begin
          rot_en = tick;
          if (!run) next_state = IDLE;
        end
        LOAD:    next_state = run ? RUN : IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
    if (CPU_RESET) state <= IDLE;
    else           state <= next_state;
  end

  // Datapath: word, valid pulse, tick counter and last-seen pattern select
  always_ff @(posedge CLK100MHZ or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      t        <= RESET_WORD;
      t_valid  <= 1'b0;
      tick_cnt <= '0;
      pat_q    <= 2'b00;
    end else begin
      t_valid <= 1'b0;
      if (state == LOAD) begin
        t       <= pattern_word(pat_q);
        t_valid <= 1'b1;
      end else if (rot_en) begin
        t       <= rotate_nibble(t, dir);
        t_valid <= 1'b1;
      end
      if (pat_chg) pat_q <= sw_deb[1:0];
      if (state == RUN && next_state == RUN) tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      else                                   tick_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_nibble_rotator.sv
// Directed bench for nibble_rotator with TICK_DIV = 4, DEB_CYCLES = 3.
module tb_nibble_rotator;

  logic        clk;
  logic        rst;
  logic [3:0]  sw;
  logic [15:0] t;
  logic        t_valid;

  int n_vec = 0;
  int n_err = 0;

  nibble_rotator #(.TICK_DIV(4), .DEB_CYCLES(3)) dut (
    .CLK100MHZ (clk),
    .CPU_RESET (rst),
    .sw_raw    (sw),
    .t         (t),
    .t_valid   (t_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_out(input string tag, input logic [15:0] t_exp, input logic v_exp);
    check_val({tag, ".t"}, t, t_exp);
    check_val({tag, ".valid"}, {15'd0, t_valid}, {15'd0, v_exp});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    sw  = 4'b0000;
    #2 rst = 1'b1;
    #1 expect_out("rst_async", 16'h0123, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      expect_out("rst_hold", 16'h0123, 1'b0);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      expect_out("post_rst", 16'h0123, 1'b0);
    end

    // Two-cycle glitch on run must be rejected
    sw = 4'b1000;
    step(2);
    sw = 4'b0000;
    for (int i = 0; i < 15; i++) begin
      step(1);
      expect_out("glitch", 16'h0123, 1'b0);
    end

    // Held run, pattern 00, left: first rotation 10 edges after the switch
    sw = 4'b1000;
    for (int i = 0; i < 9; i++) begin
      step(1);
      expect_out("run_wait", 16'h0123, 1'b0);
    end
    step(1); expect_out("rotl_1", 16'h1230, 1'b1);
    step(1); expect_out("rotl_1q", 16'h1230, 1'b0);
    step(3); expect_out("rotl_2", 16'h2301, 1'b1);
    step(1); expect_out("rotl_2q", 16'h2301, 1'b0);
    step(3); expect_out("rotl_3", 16'h3012, 1'b1);
    step(1); expect_out("rotl_3q", 16'h3012, 1'b0);
    step(3); expect_out("rotl_4", 16'h0123, 1'b1);

    // Drop run off-tick: one more rotation lands before the debounce, then hold
    sw = 4'b0000;
    step(4); expect_out("stop_rot", 16'h1230, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1);
      expect_out("stop_hold", 16'h1230, 1'b0);
    end

    // Pattern 01, right, run
    sw = 4'b1101;
    for (int i = 0; i < 6; i++) begin
      step(1);
      expect_out("p01_wait", 16'h1230, 1'b0);
    end
    step(1); expect_out("p01_load", 16'hABCD, 1'b1);
    step(1); expect_out("p01_loadq", 16'hABCD, 1'b0);
    step(3); expect_out("p01_rotr1", 16'hDABC, 1'b1);
    step(4); expect_out("p01_rotr2", 16'hCDAB, 1'b1);

    // Pattern change debounced exactly on a tick cycle: load wins
    step(2); sw = 4'b1110;
    step(2); expect_out("coin_rot", 16'hBCDA, 1'b1);
    step(3); expect_out("coin_pre", 16'hBCDA, 1'b0);
    step(1); expect_out("coin_norot", 16'hBCDA, 1'b0);
    step(1); expect_out("coin_load", 16'h000F, 1'b1);
    step(3); expect_out("coin_wait", 16'h000F, 1'b0);
    step(1); expect_out("coin_rotr", 16'hF000, 1'b1);

    // Direction flip mid-run takes effect at the following tick
    sw = 4'b1010;
    step(4); expect_out("dir_old", 16'h0F00, 1'b1);
    step(3); expect_out("dir_gap", 16'h0F00, 1'b0);
    step(1); expect_out("dir_new", 16'hF000, 1'b1);

    // Run drops on a tick cycle: that rotation completes, then t holds
    step(2); sw = 4'b0010;
    step(2); expect_out("drop_rot1", 16'h000F, 1'b1);
    step(4); expect_out("drop_rot2", 16'h00F0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1);
      expect_out("drop_hold", 16'h00F0, 1'b0);
    end

    // Reset mid-run, then a switch already high is picked up after release
    sw = 4'b1010;
    step(9);  expect_out("rr_wait", 16'h00F0, 1'b0);
    step(1);  expect_out("rr_rot", 16'h0F00, 1'b1);
    step(2);
    #3 rst = 1'b1;
    #1 expect_out("rr_async", 16'h0123, 1'b0);
    step(3); expect_out("rr_hold", 16'h0123, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      expect_out("rr_deb", 16'h0123, 1'b0);
    end
    step(1); expect_out("rr_load", 16'h000F, 1'b1);
    step(3); expect_out("rr_gap", 16'h000F, 1'b0);
    step(1); expect_out("rr_rotl", 16'h00F0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nibble_rotator.md
NIBBLE_ROTATOR -- requirements
Module: nibble_rotator

Interface
REQ-001 Parameter TICK_DIV, default 25_000_000: CLK100MHZ cycles per rotation step (4 Hz); legal range >= 2.
REQ-002 Parameter DEB_CYCLES, default 1_000_000: consecutive stable cycles before a switch change is accepted (10 ms); legal range >= 2.
REQ-003 CLK100MHZ  input  1  sole clock; all state rising-edge.
REQ-004 CPU_RESET  input  1  reset, asynchronous, active-high.
REQ-005 sw_raw  input  4  raw board switches, asynchronous: [1:0] pattern select, [2] direction (0 = left, 1 = right), [3] run (1 = rotate, 0 = hold).
REQ-006 t  output  16  four-nibble hex word, registered, feeds the seven-segment display driver directly.
REQ-007 t_valid  output  1  one-cycle pulse in the cycle t takes a new value.

Function
REQ-008 Each sw_raw bit SHALL pass a 2-flop synchronizer, then a debouncer; the debounced bit updates only after the synchronized bit differs from it for DEB_CYCLES consecutive cycles, and any reversion restarts the count at 0.
REQ-009 Pattern table, indexed by debounced [1:0]: 00 -> 16'h0123, 01 -> 16'hABCD, 10 -> 16'h000F, 11 -> 16'hF0F0.
REQ-010 Rotate left: t <= {t[11:0], t[15:12]}; rotate right: t <= {t[3:0], t[15:4]}; the rotation is a whole nibble, with no bit loss and wrap-around at both ends.
REQ-011 FSM states: IDLE (hold t), RUN (rotate on tick), LOAD (one cycle, t <= pattern).
REQ-012 Transitions: any state -> LOAD when the debounced pattern select changes; LOAD -> RUN if debounced run = 1, else IDLE; IDLE -> RUN when run becomes 1; RUN -> IDLE when run becomes 0.
REQ-013 Tick counter: counts 0..TICK_DIV-1 only in RUN; a tick is asserted when count = TICK_DIV-1, after which the counter wraps to 0; the counter clears to 0 in IDLE and LOAD.
REQ-014 On a tick in RUN, t rotates in the same clock edge using the current debounced direction; the first rotation after entering RUN occurs exactly TICK_DIV cycles later.
REQ-015 A pattern change arriving in the same cycle as a tick: the load wins, no rotation occurs, and the tick counter restarts.
REQ-016 A direction change while in RUN takes effect at the next tick; it neither reloads t nor resets the counter.
REQ-017 A run change arriving in the same cycle as a tick: the tick's rotation completes first, then the state moves to IDLE.
REQ-018 t_valid = 1 in exactly the cycle after a LOAD write or a rotation edge, aligned with the new t; it is 0 otherwise.
REQ-019 A LOAD whose pattern equals the current t still pulses t_valid.

Reset
REQ-020 While CPU_RESET = 1, regardless of the clock: t = 16'h0123, t_valid = 0, state = IDLE, tick counter = 0, debounce counters = 0, synchronizer flops = 0, and debounced bits = 0 (pattern 00, left, hold).
REQ-021 After CPU_RESET deasserts, a switch already high is accepted after 2 + DEB_CYCLES cycles and handled per REQ-012.
REQ-022 Reset asserted mid-rotation or mid-debounce SHALL abort the operation, with no partial update of t.

Structure
REQ-023 Package nibble_rot_pkg SHALL hold the FSM state enum (IDLE, RUN, LOAD), the four pattern constants, the direction encoding, and the reset word 16'h0123.
REQ-024 One sub-module, sw_debounce (1-bit, parameter DEB_CYCLES, includes the synchronizer), is instantiated four times; the FSM, tick counter and rotator stay in nibble_rotator.

Verification (TICK_DIV = 4, DEB_CYCLES = 3)
REQ-025 Reset with sw_raw = 4'b0000: t = 16'h0123 and t_valid = 0 throughout; assert reset mid-run: t returns to 16'h0123 asynchronously.
REQ-026 Debounce: a 2-cycle glitch on sw_raw[3] gives no state change; a held 1 enters RUN after 5 cycles; rotation left thereafter gives 16'h1230, 16'h2301, 16'h3012, 16'h0123 every 4 cycles, each with a t_valid pulse.
REQ-027 Pattern 01, right, run: after the load t = 16'hABCD, then 16'hDABC, then 16'hCDAB.
REQ-028 Pattern change timed to coincide with a tick: t = new pattern, no rotation that cycle, and the next rotation comes 4 cycles after LOAD.
REQ-029 Direction flip mid-RUN: the next tick rotates in the new direction at the normal 4-cycle spacing; the run bit dropping on a tick cycle completes that rotation, then t holds.
